// File: rtl/lfsr.sv
// Fibonacci LFSR pseudo-random bit source with synchronous seed load.
// Define LFSR_ZERO_GUARD_EN to replace any all-zero state or zero seed with RESET_SEED.
module lfsr #(
  parameter int                WIDTH      = 4,
  parameter int unsigned       TAP_MASK   = 0,
  parameter logic [WIDTH-1:0]  RESET_SEED = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic             q,
  input  logic [WIDTH-1:0] seed,
  input  logic             load
);

  // Maximal-length taps; exponent e of the polynomial maps to state bit e-1.
  function automatic logic [31:0] builtin_taps(input int w);
    case (w)
      2:       builtin_taps = 32'h0000_0003;
      3:       builtin_taps = 32'h0000_0006;
      4:       builtin_taps = 32'h0000_000C;
      5:       builtin_taps = 32'h0000_0014;
      6:       builtin_taps = 32'h0000_0030;
      7:       builtin_taps = 32'h0000_0060;
      8:       builtin_taps = 32'h0000_00B8;
      9:       builtin_taps = 32'h0000_0110;
      10:      builtin_taps = 32'h0000_0240;
      11:      builtin_taps = 32'h0000_0500;
      12:      builtin_taps = 32'h0000_0E08;
      13:      builtin_taps = 32'h0000_1C80;
      14:      builtin_taps = 32'h0000_3802;
      15:      builtin_taps = 32'h0000_6000;
      16:      builtin_taps = 32'h0000_D008;
      default: builtin_taps = 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]      BUILTIN = builtin_taps(WIDTH);
  localparam logic [31:0]      MASK32  = (TAP_MASK != 0) ? 32'(TAP_MASK) : BUILTIN;
  localparam logic [WIDTH-1:0] TAPS    = MASK32[WIDTH-1:0];

  generate
    if (TAP_MASK == 0 && (WIDTH < 2 || WIDTH > 16)) begin : g_bad_width
      $error("lfsr: no built-in tap table for WIDTH=%0d", WIDTH);
    end
    if (RESET_SEED == '0) begin : g_bad_seed
      $error("lfsr: RESET_SEED must be nonzero");
    end
  endgenerate

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] shifted;
  logic             fb;

  assign fb      = ^(state_reg & TAPS);
  assign shifted = {state_reg[WIDTH-2:0], fb};

  always_comb begin
    state_next = shifted;
    if (load) begin
`ifdef LFSR_ZERO_GUARD_EN
      state_next = (seed == '0) ? RESET_SEED : seed;
`else
      state_next = seed;
`endif
    end else begin
`ifdef LFSR_ZERO_GUARD_EN
      // All-zero is a fixed point of the XOR feedback; kick it back onto the cycle.
      state_next = (state_reg == '0) ? RESET_SEED : shifted;
`else
      state_next = shifted;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RESET_SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign q = state_reg[WIDTH-1];

endmodule

// File: tb/tb_lfsr.sv
// Directed testbench for lfsr: default WIDTH=4 plus WIDTH=8 and WIDTH=16 period checks.
module tb_lfsr;

  logic        clk = 1'b0;
  logic        rst, load, q;
  logic [3:0]  seed;
  logic        rst8, load8, q8;
  logic [7:0]  seed8;
  logic        rst16, load16, q16;
  logic [15:0] seed16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lfsr dut (.clk(clk), .rst(rst), .q(q), .seed(seed), .load(load));
  lfsr #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .q(q8), .seed(seed8), .load(load8));
  lfsr #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .q(q16), .seed(seed16), .load(load16));

  // One rising edge; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] exp_q;
    exp_q = 16'b1111_0001_0011_0101;   // MSB first: q over 16 states from 1111
    rst = 1'b1; step(); rst = 1'b0;
    if (q !== 1'b1) begin
      $display("FAIL reset_q: got %b want 1", q); mismatched++;
    end
    compared++;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (q !== exp_q[15-i]) begin
        $display("FAIL reset_seq[%0d]: got %b want %b", i, q, exp_q[15-i]); mismatched++;
      end
      compared++;
    end
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    if (q !== 1'b1) begin
      $display("FAIL reset_mid_q: got %b want 1", q); mismatched++;
    end
    compared++;
  endtask

  task automatic test_load();
    logic [4:0] exp_q;
    exp_q = 5'b11110;                  // states 1111,1110,1100,1000,0001
    seed = 4'b1111; load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      if (q !== exp_q[4-i]) begin
        $display("FAIL load_seq[%0d]: got %b want %b", i, q, exp_q[4-i]); mismatched++;
      end
      compared++;
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_a, exp_b;
    exp_a = 4'b1111;                   // 1111,1110,1100,1000
    exp_b = 4'b0101;                   // 0101,1011,0111,1111
    for (int i = 0; i < 3; i++) step();
    seed = 4'b0101; rst = 1'b1; load = 1'b1; step(); rst = 1'b0; load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (q !== exp_a[3-i]) begin
        $display("FAIL prio_rst[%0d]: got %b want %b", i, q, exp_a[3-i]); mismatched++;
      end
      compared++;
    end
    load = 1'b1; step(); load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      if (q !== exp_b[3-i]) begin
        $display("FAIL prio_load[%0d]: got %b want %b", i, q, exp_b[3-i]); mismatched++;
      end
      compared++;
    end
  endtask

  task automatic test_load_hold();
    logic [3:0] exp_q;
    exp_q = 4'b0001;                   // after release: 0001,0010,0100,1001
    seed = 4'b1000; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (q !== 1'b1) begin
        $display("FAIL hold[%0d]: got %b want 1", i, q); mismatched++;
      end
      compared++;
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (q !== exp_q[3-i]) begin
        $display("FAIL hold_release[%0d]: got %b want %b", i, q, exp_q[3-i]); mismatched++;
      end
      compared++;
    end
  endtask

  task automatic test_zero_seed();
    seed = 4'b0000; load = 1'b1; step(); load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    begin
      logic [4:0] exp_q;
      exp_q = 5'b11110;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        if (q !== exp_q[4-i]) begin
          $display("FAIL zero_guard[%0d]: got %b want %b", i, q, exp_q[4-i]); mismatched++;
        end
        compared++;
      end
    end
`else
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      if (q !== 1'b0) begin
        $display("FAIL zero_lock[%0d]: got %b want 0", i, q); mismatched++;
      end
      compared++;
    end
`endif
  endtask

  // State at cycle t is q(t..t+W-1), MSB first; a sliding window of q rebuilds it.
  task automatic test_period8();
    logic [7:0] win;
    int found;
    found = -1;
    win = '0;
    seed8 = 8'd1; load8 = 1'b1; step(); load8 = 1'b0;
    for (int k = 0; k < 300 && found < 0; k++) begin
      if (k > 0) step();
      win = {win[6:0], q8};
      if (k >= 8 && win == 8'd1) found = k - 7;
    end
    if (found != 255) begin
      $display("FAIL period8: got %0d want 255", found); mismatched++;
    end
    compared++;
  endtask

  task automatic test_period16();
    logic [15:0] win;
    int found;
    found = -1;
    win = '0;
    seed16 = 16'd1; load16 = 1'b1; step(); load16 = 1'b0;
    for (int k = 0; k < 65600 && found < 0; k++) begin
      if (k > 0) step();
      win = {win[14:0], q16};
      if (k >= 16 && win == 16'd1) found = k - 15;
    end
    if (found != 65535) begin
      $display("FAIL period16: got %0d want 65535", found); mismatched++;
    end
    compared++;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; seed = '0;
    rst8 = 1'b1; load8 = 1'b0; seed8 = '0;
    rst16 = 1'b1; load16 = 1'b0; seed16 = '0;
    @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    test_reset();
    test_load();
    test_priority();
    test_load_hold();
    test_zero_seed();
    test_period8();
    test_period16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
